// File: rtl/scan_capture_pkg.sv
// Shared constants for the seven-segment scan receiver: active-low segment patterns,
// BCD codes for blank/illegal digits, digit-select codes and FSM state encodings.
package scan_capture_pkg;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // Active-low {g,f,e,d,c,b,a} patterns of a common-anode display
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] BCD_BLANK = 4'hA;
  localparam logic [3:0] BCD_ERR   = 4'hF;

  localparam logic [1:0] COL_ONES = 2'b10;
  localparam logic [1:0] COL_TENS = 2'b01;

endpackage

// File: rtl/seg_decode_mod.sv
// Combinational seven-segment pattern to BCD decoder; zero latency, no flow control.
// Blank decodes to BCD_BLANK, any illegal pattern to BCD_ERR with err set.
module seg_decode_mod
  import scan_capture_pkg::*;
(
  input  logic [6:0] seg_pat,
  output logic [3:0] bcd,
  output logic       err
);

  always_comb begin
    bcd = BCD_ERR;
    err = 1'b1;
    case (seg_pat)
      SEG_0:     begin bcd = 4'd0;      err = 1'b0; end
      SEG_1:     begin bcd = 4'd1;      err = 1'b0; end
      SEG_2:     begin bcd = 4'd2;      err = 1'b0; end
      SEG_3:     begin bcd = 4'd3;      err = 1'b0; end
      SEG_4:     begin bcd = 4'd4;      err = 1'b0; end
      SEG_5:     begin bcd = 4'd5;      err = 1'b0; end
      SEG_6:     begin bcd = 4'd6;      err = 1'b0; end
      SEG_7:     begin bcd = 4'd7;      err = 1'b0; end
      SEG_8:     begin bcd = 4'd8;      err = 1'b0; end
      SEG_9:     begin bcd = 4'd9;      err = 1'b0; end
      SEG_BLANK: begin bcd = BCD_BLANK; err = 1'b0; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/scan_capture_mod.sv
// Two-digit scanned display receiver: outputs update SETTLE+4 edges after pins settle; no backpressure.
// SCAN_CAPTURE_DP_EN adds decimal-point capture; otherwise Row[7] is ignored and dp outputs are 0.
module scan_capture_mod
  import scan_capture_pkg::*;
#(
  parameter logic [18:0] SETTLE = 19'd49_999
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [7:0] Row_Scan_Sig,
  input  logic [1:0] Column_Scan_Sig,
  output logic [3:0] ten_bcd,
  output logic [3:0] one_bcd,
  output logic       ten_dp,
  output logic       one_dp,
  output logic       ten_err,
  output logic       one_err,
  output logic       frame_done
);

`ifdef SCAN_CAPTURE_DP_EN
  localparam int RW = 8;
`else
  localparam int RW = 7;
  logic unused_row7;
  assign unused_row7 = Row_Scan_Sig[7];
`endif
  localparam int SW = RW + 2;

  logic [RW-1:0] row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic [1:0]    col_s1_q, col_s1_d, col_s2_q, col_s2_d;
  logic [SW-1:0] prev_q, prev_d, sample;
  state_t        state_q, state_d;
  logic [18:0]   count_q, count_d;
  logic [3:0]    ten_bcd_q, ten_bcd_d, one_bcd_q, one_bcd_d;
  logic          ten_err_q, ten_err_d, one_err_q, one_err_d;
  logic          got_one_q, got_one_d, got_ten_q, got_ten_d;
  logic          frame_done_q, frame_done_d;
  logic          mismatch, capture, cap_one, cap_ten;
  logic [3:0]    dec_bcd;
  logic          dec_err;

  // The synchronized segment bus is stable whenever it is captured, so one decoder serves both digits.
  seg_decode_mod u_seg_decode (
    .seg_pat (row_s2_q[6:0]),
    .bcd     (dec_bcd),
    .err     (dec_err)
  );

  always_comb begin
    row_s1_d = Row_Scan_Sig[RW-1:0];
    row_s2_d = row_s1_q;
    col_s1_d = Column_Scan_Sig;
    col_s2_d = col_s1_q;
    sample   = {col_s2_q, row_s2_q};
    prev_d   = sample;
    mismatch = (sample != prev_q);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    capture = 1'b0;
    if (mismatch) begin
      state_d = S_WAIT;
      count_d = '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (count_q == SETTLE) begin
            capture = 1'b1;
            state_d = S_HOLD;
          end else begin
            count_d = count_q + 19'd1;
          end
        end
        S_HOLD: begin
          if (count_q != '1) count_d = count_q + 19'd1;
        end
        default: state_d = S_WAIT;
      endcase
    end
  end

  assign cap_one = capture && (col_s2_q == COL_ONES);
  assign cap_ten = capture && (col_s2_q == COL_TENS);

  // The capture that completes the pair raises frame_done and starts a fresh frame.
  always_comb begin
    one_bcd_d    = one_bcd_q;
    one_err_d    = one_err_q;
    ten_bcd_d    = ten_bcd_q;
    ten_err_d    = ten_err_q;
    got_one_d    = got_one_q;
    got_ten_d    = got_ten_q;
    frame_done_d = 1'b0;
    if (cap_one) begin
      one_bcd_d = dec_bcd;
      one_err_d = dec_err;
      if (got_ten_q) begin
        frame_done_d = 1'b1;
        got_one_d    = 1'b0;
        got_ten_d    = 1'b0;
      end else begin
        got_one_d = 1'b1;
      end
    end
    if (cap_ten) begin
      ten_bcd_d = dec_bcd;
      ten_err_d = dec_err;
      if (got_one_q) begin
        frame_done_d = 1'b1;
        got_one_d    = 1'b0;
        got_ten_d    = 1'b0;
      end else begin
        got_ten_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      row_s1_q     <= '1;
      row_s2_q     <= '1;
      col_s1_q     <= 2'b11;
      col_s2_q     <= 2'b11;
      prev_q       <= '1;
      state_q      <= S_WAIT;
      count_q      <= '0;
      ten_bcd_q    <= '0;
      one_bcd_q    <= '0;
      ten_err_q    <= 1'b0;
      one_err_q    <= 1'b0;
      got_one_q    <= 1'b0;
      got_ten_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      row_s1_q     <= row_s1_d;
      row_s2_q     <= row_s2_d;
      col_s1_q     <= col_s1_d;
      col_s2_q     <= col_s2_d;
      prev_q       <= prev_d;
      state_q      <= state_d;
      count_q      <= count_d;
      ten_bcd_q    <= ten_bcd_d;
      one_bcd_q    <= one_bcd_d;
      ten_err_q    <= ten_err_d;
      one_err_q    <= one_err_d;
      got_one_q    <= got_one_d;
      got_ten_q    <= got_ten_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef SCAN_CAPTURE_DP_EN
  logic ten_dp_q, ten_dp_d, one_dp_q, one_dp_d;

  always_comb begin
    ten_dp_d = ten_dp_q;
    one_dp_d = one_dp_q;
    if (cap_one) one_dp_d = ~row_s2_q[7];
    if (cap_ten) ten_dp_d = ~row_s2_q[7];
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ten_dp_q <= 1'b0;
      one_dp_q <= 1'b0;
    end else begin
      ten_dp_q <= ten_dp_d;
      one_dp_q <= one_dp_d;
    end
  end

  assign ten_dp = ten_dp_q;
  assign one_dp = one_dp_q;
`else
  assign ten_dp = 1'b0;
  assign one_dp = 1'b0;
`endif

  assign ten_bcd    = ten_bcd_q;
  assign one_bcd    = one_bcd_q;
  assign ten_err    = ten_err_q;
  assign one_err    = one_err_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_capture_mod.sv
// Bench for scan_capture_mod: table vectors, hand-built corner sequences and random
// pin activity, all checked every cycle against a pin-history reference model.
module tb_scan_capture_mod;

  localparam logic [18:0] SETTLE = 19'd20;
  localparam int ST = 20;
`ifdef SCAN_CAPTURE_DP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic [7:0] row = 8'hFF;
  logic [1:0] col = 2'b11;
  logic [3:0] ten_bcd, one_bcd;
  logic       ten_dp, one_dp, ten_err, one_err, frame_done;

  always #5 CLK = ~CLK;

  scan_capture_mod #(.SETTLE(SETTLE)) dut (
    .CLK             (CLK),
    .RST_n           (RST_n),
    .Row_Scan_Sig    (row),
    .Column_Scan_Sig (col),
    .ten_bcd         (ten_bcd),
    .one_bcd         (one_bcd),
    .ten_dp          (ten_dp),
    .one_dp          (one_dp),
    .ten_err         (ten_err),
    .one_err         (one_err),
    .frame_done      (frame_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame_cnt = 0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Reference model: a capture happens two edges after the pins have been seen unchanged for ST+2 edges.
  logic [9:0] m_last, p1_k, p2_k;
  int         m_run;
  bit         p1_v, p2_v;
  logic [3:0] m_ten, m_one;
  bit         m_tdp, m_odp, m_terr, m_oerr, m_gt, m_go, m_frame;

  function automatic logic [9:0] mkey(input logic [1:0] c, input logic [7:0] r);
    return {c, (DP_EN ? r : {1'b0, r[6:0]})};
  endfunction

  task automatic decode(input logic [7:0] r, output logic [3:0] b, output bit e);
    logic [7:0] s;
    b = 4'hF;
    e = 1'b1;
    if (r[6:0] == 7'h7F) begin b = 4'hA; e = 1'b0; end
    for (int i = 0; i < 10; i++) begin
      s = seg_tab[i];
      if (r[6:0] == s[6:0]) begin b = 4'(i); e = 1'b0; end
    end
  endtask

  task automatic model_reset();
    m_last = mkey(2'b11, 8'hFF);
    m_run = 0;
    p1_v = 0; p2_v = 0; p1_k = '0; p2_k = '0;
    m_ten = 0; m_one = 0; m_tdp = 0; m_odp = 0; m_terr = 0; m_oerr = 0;
    m_gt = 0; m_go = 0; m_frame = 0;
  endtask

  task automatic model_apply(input logic [9:0] k);
    logic [3:0] b;
    bit e;
    decode(k[7:0], b, e);
    if (k[9:8] == 2'b10) begin
      m_one = b; m_oerr = e; m_odp = DP_EN & ~k[7];
      if (m_gt) begin m_frame = 1; m_gt = 0; m_go = 0; end else m_go = 1;
    end else if (k[9:8] == 2'b01) begin
      m_ten = b; m_terr = e; m_tdp = DP_EN & ~k[7];
      if (m_go) begin m_frame = 1; m_gt = 0; m_go = 0; end else m_gt = 1;
    end
  endtask

  task automatic model_edge(input logic [1:0] c, input logic [7:0] r);
    logic [9:0] k;
    k = mkey(c, r);
    m_frame = 0;
    if (p2_v) model_apply(p2_k);
    p2_v = p1_v; p2_k = p1_k;
    if (k == m_last) m_run++;
    else begin m_last = k; m_run = 1; end
    p1_v = (m_run == ST + 2);
    p1_k = k;
  endtask

  function automatic logic [14:0] outvec();
    return {ten_bcd, one_bcd, ten_dp, one_dp, ten_err, one_err, frame_done};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [1:0] c;
    logic [7:0] r;
    logic [14:0] exp;
    c = col;
    r = row;
    @(posedge CLK);
    model_edge(c, r);
    #1;
    cyc++;
    exp = {m_ten, m_one, m_tdp, m_odp, m_terr, m_oerr, m_frame};
    if (frame_done === 1'b1) frame_cnt++;
    checks++;
    if (outvec() !== exp) begin
      errors++;
      $display("FAIL model cycle %0d actual=%h expected=%h", cyc, outvec(), exp);
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    RST_n = 1'b0;
    col = 2'b11;
    row = 8'hFF;
    #1;
    chk("reset_outputs", int'(outvec()), 0);
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] col;
    logic [7:0] row;
    logic [3:0] bcd;
    bit         err;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t vt [12];
    int n, fc0;
    logic [7:0] r;
    vt[0]  = '{2'b10, 8'hF9, 4'h1, 1'b0};
    vt[1]  = '{2'b01, 8'hA4, 4'h2, 1'b0};
    vt[2]  = '{2'b10, 8'hC0, 4'h0, 1'b0};
    vt[3]  = '{2'b01, 8'h77, 4'hF, 1'b1};
    vt[4]  = '{2'b01, 8'hFF, 4'hA, 1'b0};
    vt[5]  = '{2'b10, 8'h40, 4'h0, 1'b0};
    vt[6]  = '{2'b01, 8'h90, 4'h9, 1'b0};
    vt[7]  = '{2'b10, 8'h82, 4'h6, 1'b0};
    vt[8]  = '{2'b01, 8'hB0, 4'h3, 1'b0};
    vt[9]  = '{2'b10, 8'hF8, 4'h7, 1'b0};
    vt[10] = '{2'b10, 8'h00, 4'h8, 1'b0};
    vt[11] = '{2'b10, 8'h7F, 4'hA, 1'b0};

    do_reset();
    hold(2 * ST);
    chk("idle_outputs", int'(outvec()), 0);
    chk("idle_frames", frame_cnt, 0);

    // Exact latency from pin change to ones update, then the tens capture closing the frame
    col = 2'b10; row = 8'hF9;
    n = 0;
    do begin
      step();
      n++;
    end while (one_bcd !== 4'h1 && n < 2 * ST + 20);
    chk("ones_latency", n, ST + 4);
    hold(6);
    fc0 = frame_cnt;
    col = 2'b01; row = 8'hA4;
    hold(ST + 10);
    chk("pair_ten_bcd", int'(ten_bcd), 2);
    chk("pair_one_bcd", int'(one_bcd), 1);
    chk("pair_errs", int'({ten_err, one_err}), 0);
    chk("pair_frame_pulses", frame_cnt - fc0, 1);

    // Too-short ones pattern must not be captured
    col = 2'b10; row = 8'hC0;
    hold(ST - 5);
    col = 2'b01; row = 8'hA4;
    hold(ST + 10);
    chk("glitch_one_bcd", int'(one_bcd), 1);

    // Pins change on the capture edge: old value still lands
    col = 2'b10; row = 8'hB0;
    hold(ST + 3);
    col = 2'b11; row = 8'hFF;
    hold(10);
    chk("edge_change_one_bcd", int'(one_bcd), 3);

    for (int i = 0; i < 12; i++) begin
      col = vt[i].col; row = vt[i].row;
      hold(ST + 8);
      r = vt[i].row;
      if (vt[i].col == 2'b10) begin
        chk($sformatf("vec%0d_one_bcd", i), int'(one_bcd), int'(vt[i].bcd));
        chk($sformatf("vec%0d_one_err", i), int'(one_err), int'(vt[i].err));
        chk($sformatf("vec%0d_one_dp", i), int'(one_dp), int'(DP_EN & ~r[7]));
      end else begin
        chk($sformatf("vec%0d_ten_bcd", i), int'(ten_bcd), int'(vt[i].bcd));
        chk($sformatf("vec%0d_ten_err", i), int'(ten_err), int'(vt[i].err));
        chk($sformatf("vec%0d_ten_dp", i), int'(ten_dp), int'(DP_EN & ~r[7]));
      end
    end

    // Reset in the middle of a frame clears the pending ones flag
    do_reset();
    col = 2'b10; row = 8'h99;
    hold(ST + 10);
    chk("mid_one_bcd", int'(one_bcd), 4);
    col = 2'b01; row = 8'hA4;
    hold(ST / 2);
    do_reset();
    col = 2'b01; row = 8'h92;
    fc0 = frame_cnt;
    hold(ST + 10);
    chk("post_reset_ten_bcd", int'(ten_bcd), 5);
    chk("post_reset_one_bcd", int'(one_bcd), 0);
    chk("post_reset_no_frame", frame_cnt - fc0, 0);

    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      col = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        r = seg_tab[$urandom_range(0, 9)];
        r[7] = 1'($urandom_range(0, 1));
      end else begin
        r = 8'($urandom);
      end
      row = r;
      hold(int'($urandom_range(1, 2 * ST + 8)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_capture_mod.md
# scan_capture_mod

Receive-side counterpart of the two-digit multiplexed seven-segment scan output. Samples the segment bus and digit-select lines of a scanned common-anode display and reconstructs the tens and ones digits as BCD, with per-digit pattern error flags and a frame-complete pulse. Used for board loopback self-test and for monitoring a display driven by another block.

## Interface
Parameters:
- SETTLE, 19'd49_999, stable-input cycles required before a capture (1 ms at 50 MHz)

Ports:
- CLK  input  1  system clock, all logic on posedge
- RST_n  input  1  asynchronous active-low reset
- Row_Scan_Sig  input  8  segment bus, active-low, {dp,g,f,e,d,c,b,a}
- Column_Scan_Sig  input  2  digit select, active-low; bit0 = ones, bit1 = tens
- ten_bcd  output  4  captured tens digit
- one_bcd  output  4  captured ones digit
- ten_dp  output  1  tens decimal point lit
- one_dp  output  1  ones decimal point lit
- ten_err  output  1  last tens capture was not a legal pattern
- one_err  output  1  last ones capture was not a legal pattern
- frame_done  output  1  one-cycle pulse when both digits have been captured since the previous pulse

## Operation
- Inputs pass through a 2-stage synchronizer; sync registers reset to Row 8'hFF, Column 2'b11.
- prev register holds last synchronized {Column,Row}; reset 10'h3FF.
- States: S_WAIT (counting stability), S_HOLD (captured, waiting for change). Reset: S_WAIT, count 19'd0.
- Any mismatch between synchronized sample and prev: count <= 0, state <= S_WAIT (from either state).
- S_WAIT, no mismatch: count increments; when count == SETTLE, next edge performs capture and moves to S_HOLD. count saturates (no wrap) while in S_HOLD.
- Capture with Column 2'b10: ones registers load; 2'b01: tens registers load. Column 2'b11 (none) or 2'b00 (both): no register loads, state still moves to S_HOLD.
- Decode of Row[6:0]: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 (low 7 bits of these bytes) -> BCD 0..9, err 0; 7'h7F (blank) -> 4'hA, err 0; anything else -> 4'hF, err 1.
- dp output = ~Row[7] at capture.
- got_one/got_ten flags set on respective captures; when the capture sets the second flag, frame_done pulses that same edge and both flags clear. Repeated capture of the same digit does not pulse.

## Timing
- Reset values: all outputs 0; got flags 0.
- Pin change to output update: exactly SETTLE+4 edges when pins then stay stable.
- Input change shorter than SETTLE+1 synchronized cycles: no capture, outputs unchanged.
- Change arriving on the capture edge: capture of the old value completes; new value restarts count next edge.
- Reset mid-count or mid-frame: all state, flags and outputs return to reset values immediately.

## Configuration
- SCAN_CAPTURE_DP_EN defined: ten_dp/one_dp capture ~Row[7] as above.
- Not defined: dp registers omitted, ten_dp/one_dp tied 0; Row[7] ignored everywhere, including change detection.

## Structure
- scan_capture_pkg: segment constants SEG_0..SEG_9, SEG_BLANK; BCD_BLANK (4'hA), BCD_ERR (4'hF); state encodings S_WAIT, S_HOLD.
- One combinational sub-module seg_decode_mod: 7-bit pattern in, {bcd[3:0], err} out; instantiated once, shared by both digits.

## Test plan
- Reset released, Row=FF, Column=11 held 2*SETTLE -> all outputs 0, no frame_done.
- Column=10 Row=F9, then Column=01 Row=A4, each held SETTLE+10 -> one_bcd=1, ten_bcd=2, single frame_done pulse on tens capture edge, errs 0.
- Column=10 Row=C0 held SETTLE-5 then Column=01 -> no ones capture; one_bcd unchanged.
- Column=01 Row=0x77 held -> ten_bcd=F, ten_err=1; then Row=FF -> ten_bcd=A, ten_err=0.
- With SCAN_CAPTURE_DP_EN, Column=10 Row=0x40 -> one_bcd=0, one_dp=1; without macro one_dp=0.
- Assert RST_n low during S_WAIT after one digit captured -> outputs 0; next single tens capture gives no frame_done.
